// File: rtl/axi_arbiter_w_if.sv
// -----------------------------------------------------------------------------
// axi_arbiter_w_if
// Bundles the write-address request lines of four masters, the muxed AW/W/B
// handshake signals seen on the slave side, and the grant outputs of the
// write-channel arbiter.
//
// Modports
//   slave  : view taken by the arbiter (requests/handshakes in, grants out)
//   master : view taken by the surrounding fabric or a testbench
//            (requests/handshakes out, grants in)
//
// Signals
//   m0_AWVALID..m3_AWVALID : write-address requests from masters 0..3
//   s_AWVALID, m_AWREADY   : muxed AW handshake
//   s_WVALID, s_WLAST      : muxed W valid / last beat
//   m_WREADY               : slave-side W ready
//   m_BVALID, s_BREADY     : B handshake
//   m0_wgrnt..m3_wgrnt     : one-hot write grant (write mux select)
//   wgrnt_idx              : binary index of current or last grant
//   wbusy                  : high while a grant is held
// -----------------------------------------------------------------------------
interface axi_arbiter_w_if;
    logic       m0_AWVALID;
    logic       m1_AWVALID;
    logic       m2_AWVALID;
    logic       m3_AWVALID;
    logic       s_AWVALID;
    logic       m_AWREADY;
    logic       s_WVALID;
    logic       s_WLAST;
    logic       m_WREADY;
    logic       m_BVALID;
    logic       s_BREADY;
    logic       m0_wgrnt;
    logic       m1_wgrnt;
    logic       m2_wgrnt;
    logic       m3_wgrnt;
    logic [1:0] wgrnt_idx;
    logic       wbusy;

    modport slave (
        input  m0_AWVALID, m1_AWVALID, m2_AWVALID, m3_AWVALID,
        input  s_AWVALID, m_AWREADY, s_WVALID, s_WLAST, m_WREADY,
        input  m_BVALID, s_BREADY,
        output m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt, wgrnt_idx, wbusy
    );

    modport master (
        output m0_AWVALID, m1_AWVALID, m2_AWVALID, m3_AWVALID,
        output s_AWVALID, m_AWREADY, s_WVALID, s_WLAST, m_WREADY,
        output m_BVALID, s_BREADY,
        input  m0_wgrnt, m1_wgrnt, m2_wgrnt, m3_wgrnt, wgrnt_idx, wbusy
    );
endinterface

// File: rtl/axi_arbiter_w.sv
// -----------------------------------------------------------------------------
// axi_arbiter_w
// Write-channel arbiter for four AXI masters sharing one slave. A master is
// selected in IDLE, holds its grant while the AW and last W beat complete
// (XFER), and keeps it until the B handshake finishes (RESP).
//
// Parameters
//   PRIO_FIXED : 0 = round-robin, 1 = fixed priority m0 > m1 > m2 > m3
//
// Ports
//   ACLK    : clock, all state changes on rising edge
//   ARESETn : asynchronous active-low reset
//   i_srst  : synchronous soft reset, same effect as ARESETn at the next edge
//   bus     : axi_arbiter_w_if.slave (requests, handshakes, grant outputs)
// -----------------------------------------------------------------------------
module axi_arbiter_w #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    input  logic           i_srst,
    axi_arbiter_w_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_grnt;
    logic [3:0] w_grnt_nxt;
    logic [1:0] r_idx;
    logic [1:0] w_idx_nxt;
    logic [1:0] r_last;
    logic [1:0] w_last_nxt;
    logic       r_aw_done;
    logic       w_aw_done_nxt;
    logic       r_w_done;
    logic       w_w_done_nxt;
    logic       r_busy;
    logic       w_busy_nxt;

    logic [3:0] w_req;
    logic [2:0] w_arb;
    logic       w_aw_hs;
    logic       w_wlast_hs;
    logic       w_b_hs;

    // Selects a winner from the request vector. Returns {valid, index}.
    // Round-robin walks from last+1 upward with wrap; the loop runs from the
    // lowest-priority candidate (last itself) to the highest so that the
    // last hit is the winner.
    function automatic logic [2:0] f_arbitrate(
        input logic [3:0] req,
        input logic [1:0] last,
        input logic       fixed
    );
        logic [2:0] res;
        logic [1:0] cand;
        res  = 3'b000;
        cand = 2'b00;
        if (fixed) begin
            for (int i = 3; i >= 0; i--) begin
                if (req[i]) begin
                    res = {1'b1, 2'(i)};
                end else begin
                    res = res;
                end
            end
        end else begin
            for (int k = 4; k >= 1; k--) begin
                cand = last + 2'(k);
                if (req[cand]) begin
                    res = {1'b1, cand};
                end else begin
                    res = res;
                end
            end
        end
        return res;
    endfunction

    // One-hot decode of a 2-bit master index.
    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign w_req      = {bus.m3_AWVALID, bus.m2_AWVALID, bus.m1_AWVALID, bus.m0_AWVALID};
    assign w_aw_hs    = bus.s_AWVALID & bus.m_AWREADY;
    assign w_wlast_hs = bus.s_WVALID & bus.m_WREADY & bus.s_WLAST;
    assign w_b_hs     = bus.m_BVALID & bus.s_BREADY;
    assign w_arb      = f_arbitrate(w_req, r_last, PRIO_FIXED);

    // Next-state, next-grant and completion-flag logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_grnt_nxt    = r_grnt;
        w_idx_nxt     = r_idx;
        w_last_nxt    = r_last;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;

        case (r_state)
            ST_IDLE: begin
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
                if (w_arb[2]) begin
                    w_state_nxt = ST_XFER;
                    w_grnt_nxt  = f_onehot(w_arb[1:0]);
                    w_idx_nxt   = w_arb[1:0];
                    w_last_nxt  = w_arb[1:0];
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grnt_nxt  = 4'b0000;
                end
            end

            ST_XFER: begin
                // AW and last W beat may finish in any order or together;
                // the edge on which the second one lands moves us to RESP.
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_wlast_hs;
                if (w_aw_done_nxt & w_w_done_nxt) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end

            ST_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt   = ST_IDLE;
                    w_grnt_nxt    = 4'b0000;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end

            default: begin
                // Unreachable encoding: drop everything and go back to IDLE.
                w_state_nxt   = ST_IDLE;
                w_grnt_nxt    = 4'b0000;
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, grant, index and flag registers with async and soft reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= ST_IDLE;
            r_grnt    <= 4'b0000;
            r_idx     <= 2'd0;
            r_last    <= 2'd3;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_busy    <= 1'b0;
        end else if (i_srst) begin
            r_state   <= ST_IDLE;
            r_grnt    <= 4'b0000;
            r_idx     <= 2'd0;
            r_last    <= 2'd3;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grnt    <= w_grnt_nxt;
            r_idx     <= w_idx_nxt;
            r_last    <= w_last_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.m0_wgrnt  = r_grnt[0];
    assign bus.m1_wgrnt  = r_grnt[1];
    assign bus.m2_wgrnt  = r_grnt[2];
    assign bus.m3_wgrnt  = r_grnt[3];
    assign bus.wgrnt_idx = r_idx;
    assign bus.wbusy     = r_busy;

endmodule

// File: tb/tb_axi_arbiter_w.sv
// -----------------------------------------------------------------------------
// tb_axi_arbiter_w
// Drives a round-robin and a fixed-priority instance with identical stimulus
// and compares both against a transaction-level model of the arbiter.
// -----------------------------------------------------------------------------
module tb_axi_arbiter_w;

    logic ACLK;
    logic ARESETn;

    logic [3:0] t_req;
    logic t_awv, t_awr, t_wv, t_wl, t_wr, t_bv, t_br, t_srst;

    int n_checks;
    int n_fail;

    // Model state, index 0 = round-robin DUT, 1 = fixed-priority DUT.
    int m_own  [2];   // granted master, -1 when none
    int m_aw   [2];
    int m_wd   [2];
    int m_resp [2];
    int m_last [2];
    int m_idx  [2];

    axi_arbiter_w_if if_rr ();
    axi_arbiter_w_if if_fx ();

    axi_arbiter_w #(.PRIO_FIXED(1'b0)) u_rr (
        .ACLK(ACLK), .ARESETn(ARESETn), .i_srst(t_srst), .bus(if_rr.slave)
    );
    axi_arbiter_w #(.PRIO_FIXED(1'b1)) u_fx (
        .ACLK(ACLK), .ARESETn(ARESETn), .i_srst(t_srst), .bus(if_fx.slave)
    );

    assign if_rr.m0_AWVALID = t_req[0];
    assign if_rr.m1_AWVALID = t_req[1];
    assign if_rr.m2_AWVALID = t_req[2];
    assign if_rr.m3_AWVALID = t_req[3];
    assign if_rr.s_AWVALID  = t_awv;
    assign if_rr.m_AWREADY  = t_awr;
    assign if_rr.s_WVALID   = t_wv;
    assign if_rr.s_WLAST    = t_wl;
    assign if_rr.m_WREADY   = t_wr;
    assign if_rr.m_BVALID   = t_bv;
    assign if_rr.s_BREADY   = t_br;

    assign if_fx.m0_AWVALID = t_req[0];
    assign if_fx.m1_AWVALID = t_req[1];
    assign if_fx.m2_AWVALID = t_req[2];
    assign if_fx.m3_AWVALID = t_req[3];
    assign if_fx.s_AWVALID  = t_awv;
    assign if_fx.m_AWREADY  = t_awr;
    assign if_fx.s_WVALID   = t_wv;
    assign if_fx.s_WLAST    = t_wl;
    assign if_fx.m_WREADY   = t_wr;
    assign if_fx.m_BVALID   = t_bv;
    assign if_fx.s_BREADY   = t_br;

    logic [3:0] g_rr, g_fx;
    assign g_rr = {if_rr.m3_wgrnt, if_rr.m2_wgrnt, if_rr.m1_wgrnt, if_rr.m0_wgrnt};
    assign g_fx = {if_fx.m3_wgrnt, if_fx.m2_wgrnt, if_fx.m1_wgrnt, if_fx.m0_wgrnt};

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner per the arbitration rules: fixed = lowest index, RR = first
    // requester at or after last+1 going upward with wrap.
    function automatic int pick(input logic [3:0] rq, input int last, input int fixed);
        if (fixed != 0) begin
            for (int i = 0; i < 4; i++) if (rq[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (last + k) % 4;
                if (rq[c]) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_own[m] = -1; m_aw[m] = 0; m_wd[m] = 0; m_resp[m] = 0;
            m_last[m] = 3; m_idx[m] = 0;
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int p;
        for (int m = 0; m < 2; m++) begin
            if (t_srst) begin
                m_own[m] = -1; m_aw[m] = 0; m_wd[m] = 0; m_resp[m] = 0;
                m_last[m] = 3; m_idx[m] = 0;
            end else if (m_own[m] < 0) begin
                p = pick(t_req, m_last[m], m);
                if (p >= 0) begin
                    m_own[m] = p; m_idx[m] = p; m_last[m] = p;
                end
            end else if (m_resp[m] == 0) begin
                if (t_awv && t_awr) m_aw[m] = 1;
                if (t_wv && t_wr && t_wl) m_wd[m] = 1;
                if (m_aw[m] != 0 && m_wd[m] != 0) m_resp[m] = 1;
            end else if (t_bv && t_br) begin
                m_own[m] = -1; m_aw[m] = 0; m_wd[m] = 0; m_resp[m] = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_vec(input int m);
        if (m_own[m] < 0) return 4'b0000;
        return 4'b0001 << m_own[m];
    endfunction

    task automatic compare_all();
        chk("rr_grant", g_rr, exp_vec(0));
        chk("rr_idx", if_rr.wgrnt_idx, m_idx[0]);
        chk("rr_busy", if_rr.wbusy, (m_own[0] >= 0));
        chk("rr_onehot", $onehot0(g_rr), 1);
        chk("rr_idx_match", (g_rr == 4'b0000) || (g_rr == (4'b0001 << if_rr.wgrnt_idx)), 1);
        chk("fx_grant", g_fx, exp_vec(1));
        chk("fx_idx", if_fx.wgrnt_idx, m_idx[1]);
        chk("fx_busy", if_fx.wbusy, (m_own[1] >= 0));
        chk("fx_onehot", $onehot0(g_fx), 1);
        chk("fx_idx_match", (g_fx == 4'b0000) || (g_fx == (4'b0001 << if_fx.wgrnt_idx)), 1);
    endtask

    // One clock: drive inputs, step the model, compare at the falling edge.
    task automatic cyc(input logic [3:0] rq, input logic awv, input logic awr,
                       input logic wv, input logic wl, input logic wr,
                       input logic bv, input logic br, input logic sr);
        t_req = rq; t_awv = awv; t_awr = awr; t_wv = wv; t_wl = wl; t_wr = wr;
        t_bv = bv; t_br = br; t_srst = sr;
        model_step();
        @(posedge ACLK);
        @(negedge ACLK);
        compare_all();
    endtask

    task automatic zero_inputs();
        t_req = 4'b0000; t_awv = 1'b0; t_awr = 1'b0; t_wv = 1'b0; t_wl = 1'b0;
        t_wr = 1'b0; t_bv = 1'b0; t_br = 1'b0; t_srst = 1'b0;
    endtask

    task automatic do_reset();
        zero_inputs();
        ARESETn = 1'b0;
        model_reset();
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    // One full transaction with the given requests: grant, AW+W-last, B.
    task automatic txn(input logic [3:0] rq, input string tag,
                       input logic [3:0] exp_rr, input logic [3:0] exp_fx);
        cyc(rq, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_rr"}, g_rr, exp_rr);
        chk({tag, "_fx"}, g_fx, exp_fx);
        cyc(rq, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, "_rr_hold"}, g_rr, exp_rr);
        cyc(rq, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk({tag, "_rr_done"}, g_rr, 4'b0000);
    endtask

    logic [3:0] ord33 [5];
    logic [3:0] ord34 [3];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ord33 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ord34 = '{4'b0010, 4'b1000, 4'b0010};
        zero_inputs();
        ARESETn = 1'b0;
        model_reset();
        @(negedge ACLK);
        @(negedge ACLK);
        chk("rst_grant_rr", g_rr, 4'b0000);
        chk("rst_grant_fx", g_fx, 4'b0000);
        chk("rst_idx", if_rr.wgrnt_idx, 2'd0);
        chk("rst_busy", if_rr.wbusy, 1'b0);
        ARESETn = 1'b1;

        // m2 alone, dropping AWVALID after grant; AW then 4 W beats, then B.
        cyc(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("m2_grant", g_rr, 4'b0100);
        chk("m2_idx", if_rr.wgrnt_idx, 2'd2);
        cyc(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++)
            cyc(4'b0000, 1'b0, 1'b0, 1'b1, (b == 3), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("m2_hold_resp", g_rr, 4'b0100);
        chk("m2_busy_resp", if_rr.wbusy, 1'b1);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("m2_release", g_rr, 4'b0000);
        chk("m2_idle_busy", if_rr.wbusy, 1'b0);

        // All four requesting: RR order m0..m3,m0; fixed always m0.
        do_reset();
        for (int t = 0; t < 5; t++) txn(4'b1111, "rr_order", ord33[t], 4'b0001);

        // m1 and m3 requesting: fixed keeps m1, RR alternates.
        for (int t = 0; t < 3; t++) txn(4'b1010, "m1m3", ord34[t], 4'b0010);

        // W-last before AW with an early B in XFER; then same-cycle AW+W-last.
        cyc(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wfirst_grant", g_rr, 4'b0001);
        cyc(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("early_b_hold", g_rr, 4'b0001);
        cyc(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wfirst_resp_hold", g_rr, 4'b0001);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("wfirst_release", g_rr, 4'b0000);
        cyc(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("same_cycle_release", g_rr, 4'b0000);

        // Reset mid-XFER with m1 granted; then m0 wins over m1.
        cyc(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_m1_rr", g_rr, 4'b0010);
        chk("pre_rst_m1_fx", g_fx, 4'b0010);
        cyc(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        zero_inputs();
        #2;
        ARESETn = 1'b0;
        model_reset();
        #1;
        chk("midrst_grant_rr", g_rr, 4'b0000);
        chk("midrst_grant_fx", g_fx, 4'b0000);
        chk("midrst_busy", if_rr.wbusy, 1'b0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        cyc(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_m0_rr", g_rr, 4'b0001);
        chk("post_rst_m0_fx", g_fx, 4'b0001);
        cyc(4'b0011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Randomized traffic against the model, with rare soft resets.
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] rq;
            rq = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            cyc(rq,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_arbiter_w.md
AXI_ARBITER_W -- requirements
Module: axi_arbiter_w

Interface
REQ-001 Parameter: PRIO_FIXED, 0, arbitration mode; 0 = round-robin, 1 = fixed priority with m0 > m1 > m2 > m3.
REQ-002 Port: ACLK  in  1  single clock; all state changes on rising edge.
REQ-003 Port: ARESETn  in  1  reset; asynchronous, active-low.
REQ-004 Port: m0_AWVALID..m3_AWVALID  in  1 each  write-address request from masters 0..3.
REQ-005 Port: s_AWVALID  in  1  muxed AWVALID as presented to the slave side.
REQ-006 Port: m_AWREADY  in  1  slave-side AWREADY.
REQ-007 Port: s_WVALID, s_WLAST  in  1 each  muxed W-channel valid and last.
REQ-008 Port: m_WREADY  in  1  slave-side WREADY.
REQ-009 Port: m_BVALID  in  1  slave-side BVALID.
REQ-010 Port: s_BREADY  in  1  muxed BREADY.
REQ-011 Port: m0_wgrnt..m3_wgrnt  out  1 each  registered one-hot write grant; drives the write mux select.
REQ-012 Port: wgrnt_idx  out  2  binary index of the current or last grant.
REQ-013 Port: wbusy  out  1  high while any grant is held.

Function
REQ-014 FSM states: IDLE, XFER, RESP; encoding is free, but every unused code SHALL return to IDLE.
REQ-015 IDLE, any mN_AWVALID high at edge N -> winner selected combinationally, grant registered and state = XFER at edge N (grant visible in cycle N+1).
REQ-016 IDLE, no request -> all grants 0 and wbusy 0.
REQ-017 Round-robin: search starts at (last_idx+1) mod 4 and wraps; last_idx updates to winner at grant.
REQ-018 Fixed mode: lowest-numbered requester wins and last_idx is unused for selection.
REQ-019 Grants SHALL be one-hot or all-zero at all times; never two grants high.
REQ-020 XFER: aw_done flag sets on s_AWVALID & m_AWREADY; w_done flag sets on s_WVALID & m_WREADY & s_WLAST.
REQ-021 XFER: aw_done and w_done may set in either order or in the same cycle.
REQ-022 XFER -> RESP on the edge where both flags are set, including same-cycle completion of both.
REQ-023 RESP -> IDLE on m_BVALID & s_BREADY; all grants clear at that edge and both flags clear.
REQ-024 m_BVALID before RESP is ignored: no state change.
REQ-025 Grant SHALL be held through XFER and RESP even if the granted master drops AWVALID.
REQ-026 IDLE lasts at least 1 cycle between transactions, giving B-to-next-grant latency of 2 cycles.
REQ-027 The grant holder SHALL NOT change mid-transaction.
REQ-028 wbusy = (state != IDLE), registered.

Reset
REQ-029 ARESETn low SHALL asynchronously force state = IDLE, all grants 0, wbusy 0, aw_done = w_done = 0, last_idx = 3 (m0 first priority), wgrnt_idx = 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction with no grant held after deassertion.
REQ-031 First arbitration occurs on the first edge after ARESETn deasserts.

Verification
REQ-032 m2 alone: AWVALID -> m2_wgrnt = 1 next cycle; AW then 4-beat W with WLAST -> RESP; B handshake -> grant 0 one cycle later.
REQ-033 Round-robin with all four requesting continuously -> grant order m0, m1, m2, m3, m0, with exactly one grant per transaction.
REQ-034 PRIO_FIXED = 1 with m1 and m3 requesting -> m1 granted repeatedly while its AWVALID remains high.
REQ-035 W-last before AW, then same-cycle AW + W-last -> both cases enter RESP; an early m_BVALID during XFER causes no state change.
REQ-036 ARESETn pulsed low during XFER with m1 granted -> grants 0 immediately; after release with m1 and m0 requesting, m0 granted.
REQ-037 Every cycle of every scenario: grant vector one-hot or zero, and wgrnt_idx matches the asserted grant.
